// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the OPB software-register arbiter and its decoder.
package opb_arb_pkg;

  localparam int OPB_AW = 32;
  localparam int OPB_DW = 32;
  localparam int OPB_BW = OPB_DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    ACK,
    ERR,
    RTY,
    RECOVER
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_swreg_arbiter_if.sv
// OPB slave attachment plus the fan-out bundle to the downstream software-register slaves.
interface opb_swreg_arbiter_if #(
  parameter int N_SLAVES = 4
);
  import opb_arb_pkg::*;

  logic [0:OPB_AW-1]          OPB_ABus;
  logic [0:OPB_BW-1]          OPB_BE;
  logic [0:OPB_DW-1]          OPB_DBus;
  logic                       OPB_RNW;
  logic                       OPB_select;
  logic                       OPB_seqAddr;

  logic [0:OPB_DW-1]          Sl_DBus;
  logic                       Sl_xferAck;
  logic                       Sl_errAck;
  logic                       Sl_retry;
  logic                       Sl_toutSup;

  logic [N_SLAVES-1:0]        sub_select;
  logic [0:OPB_AW-1]          sub_ABus;
  logic [0:OPB_DW-1]          sub_DBus;
  logic [0:OPB_BW-1]          sub_BE;
  logic                       sub_RNW;
  logic [N_SLAVES-1:0]        sub_xferAck;
  logic [N_SLAVES-1:0]        sub_retry;
  logic [OPB_DW*N_SLAVES-1:0] sub_rdata;

  // Arbiter side: answers the OPB and drives the slaves.
  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  sub_xferAck, sub_retry, sub_rdata,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
    output sub_select, sub_ABus, sub_DBus, sub_BE, sub_RNW
  );

  // Bus/slave side: issues requests and returns slave responses.
  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output sub_xferAck, sub_retry, sub_rdata,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
    input  sub_select, sub_ABus, sub_DBus, sub_BE, sub_RNW
  );

endinterface

// File: rtl/opb_swreg_decode.sv
// Combinational window decoder: 16 windows of 2**SLAVE_SPAN_LOG2 bytes above C_BASEADDR.
module opb_swreg_decode
  import opb_arb_pkg::*;
#(
  parameter logic [OPB_AW-1:0] C_BASEADDR      = 32'h0101_4000,
  parameter int                SLAVE_SPAN_LOG2 = 8,
  parameter int                N_SLAVES        = 4
) (
  input  logic [0:OPB_AW-1] OPB_ABus,
  input  logic              OPB_select,
  output logic              hit,
  output logic [3:0]        idx,
  output logic              idx_valid
);

  localparam int TAG_LSB = SLAVE_SPAN_LOG2 + 4;

  logic [OPB_AW-1:0] addr;
  logic              unused_addr;

  // Big-endian bus bit 0 is the address MSB; positional assignment keeps the numeric value.
  assign addr        = OPB_ABus;
  assign hit         = OPB_select & (addr[OPB_AW-1:TAG_LSB] == C_BASEADDR[OPB_AW-1:TAG_LSB]);
  assign idx         = addr[TAG_LSB-1:SLAVE_SPAN_LOG2];
  assign idx_valid   = ({1'b0, idx} < 5'(N_SLAVES));
  assign unused_addr = ^addr[SLAVE_SPAN_LOG2-1:0];

endmodule

// File: rtl/opb_swreg_arbiter.sv
// Shares one OPB slave attachment between N_SLAVES software-register slaves,
// with its own ack timeout and a single registered response per transfer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a select that hits the window
// FWD     | request forwarded to one slave, timeout counter running
// ACK     | one-cycle Sl_xferAck, read data on Sl_DBus
// ERR     | one-cycle Sl_errAck + Sl_xferAck (bad index or timeout)
// RTY     | one-cycle Sl_retry
// RECOVER | one dead cycle so the master can drop select
module opb_swreg_arbiter
  import opb_arb_pkg::*;
#(
  parameter logic [OPB_AW-1:0] C_BASEADDR      = 32'h0101_4000,
  parameter int                SLAVE_SPAN_LOG2 = 8,
  parameter int                N_SLAVES        = 4,
  parameter int                TIMEOUT_CYC     = 12
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst,
  opb_swreg_arbiter_if.slave  bus
);

  localparam int CNT_W = clog2(TIMEOUT_CYC + 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                capture;

  logic                hit;
  logic [3:0]          dec_idx;
  logic                idx_valid;

  logic [3:0]          idx_q;
  logic                rnw_q;
  logic [3:0]          fwd_idx;

  logic                ack_sel;
  logic                rty_sel;
  logic [OPB_DW-1:0]   rdata_sel;
  logic [N_SLAVES-1:0] sel_n;
  logic                unused_hint;

  assign unused_hint = bus.OPB_seqAddr;

  opb_swreg_decode #(
    .C_BASEADDR      (C_BASEADDR),
    .SLAVE_SPAN_LOG2 (SLAVE_SPAN_LOG2),
    .N_SLAVES        (N_SLAVES)
  ) u_decode (
    .OPB_ABus   (bus.OPB_ABus),
    .OPB_select (bus.OPB_select),
    .hit        (hit),
    .idx        (dec_idx),
    .idx_valid  (idx_valid)
  );

  // Only the captured slave's responses are visible; everyone else is ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rty_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (idx_q == 4'(k)) begin
        ack_sel   = bus.sub_xferAck[k];
        rty_sel   = bus.sub_retry[k];
        rdata_sel = bus.sub_rdata[OPB_DW*k +: OPB_DW];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          if (idx_valid) begin
            state_n = FWD;
            cnt_n   = '0;
            capture = 1'b1;
          end else begin
            state_n = ERR;
          end
        end
      end
      FWD: begin
        cnt_n = cnt + 1'b1;
        if (!bus.OPB_select) begin
          state_n = IDLE;
        end else if (ack_sel) begin
          state_n = ACK;
        end else if (rty_sel) begin
          state_n = RTY;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_n = ERR;
        end
      end
      ACK, ERR, RTY: state_n = RECOVER;
      RECOVER:       state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // On the capture cycle the index register is still stale, so select from the decoder.
  assign fwd_idx = capture ? dec_idx : idx_q;

  always_comb begin
    sel_n = '0;
    if (state_n == FWD) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        sel_n[k] = (fwd_idx == 4'(k));
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      idx_q          <= '0;
      rnw_q          <= 1'b0;
      bus.sub_ABus   <= '0;
      bus.sub_DBus   <= '0;
      bus.sub_BE     <= '0;
      bus.sub_RNW    <= 1'b0;
      bus.sub_select <= '0;
      bus.Sl_DBus    <= '0;
      bus.Sl_xferAck <= 1'b0;
      bus.Sl_errAck  <= 1'b0;
      bus.Sl_retry   <= 1'b0;
      bus.Sl_toutSup <= 1'b0;
    end else begin
      if (capture) begin
        idx_q        <= dec_idx;
        rnw_q        <= bus.OPB_RNW;
        bus.sub_ABus <= bus.OPB_ABus;
        bus.sub_DBus <= bus.OPB_DBus;
        bus.sub_BE   <= bus.OPB_BE;
        bus.sub_RNW  <= bus.OPB_RNW;
      end
      bus.sub_select <= sel_n;
      bus.Sl_toutSup <= (state_n == FWD);
      bus.Sl_xferAck <= (state_n == ACK) || (state_n == ERR);
      bus.Sl_errAck  <= (state_n == ERR);
      bus.Sl_retry   <= (state_n == RTY);
      bus.Sl_DBus    <= ((state_n == ACK) && rnw_q) ? rdata_sel : '0;
    end
  end

endmodule

// File: tb/tb_opb_swreg_arbiter.sv
// Directed, table-driven bench for opb_swreg_arbiter with hand sequences for abort/reset/recover.
module tb_opb_swreg_arbiter;
  import opb_arb_pkg::*;

  localparam int NS = 4;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_ACK  = 3'b100;
  localparam logic [2:0] R_ERR  = 3'b110;
  localparam logic [2:0] R_RTY  = 3'b001;

  logic OPB_Clk = 1'b0;
  logic OPB_Rst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_swreg_arbiter_if #(.N_SLAVES(NS)) bus ();

  opb_swreg_arbiter #(
    .C_BASEADDR      (32'h0101_4000),
    .SLAVE_SPAN_LOG2 (8),
    .N_SLAVES        (NS),
    .TIMEOUT_CYC     (12)
  ) dut (
    .OPB_Clk (OPB_Clk),
    .OPB_Rst (OPB_Rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0]   addr;
    logic          rnw;
    logic [31:0]   wdata;
    logic [3:0]    be;
    int            slave;
    int            ack_dly;
    int            rty_dly;
    logic [NS-1:0] noise;
    logic [31:0]   rdata;
    logic [NS-1:0] exp_sel;
    logic [2:0]    exp_resp;
    logic [31:0]   exp_dbus;
    int            exp_cycle;
    int            exp_tout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge OPB_Clk);
    #1;
  endtask

  function automatic logic [5:0] resp_bits();
    return {bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup,
            |bus.Sl_DBus, |bus.sub_select};
  endfunction

  function automatic logic [31:0] all_bits();
    return {26'(resp_bits()) ^ 26'(|bus.sub_ABus) ^ 26'(|bus.sub_DBus)
            ^ 26'(|bus.sub_BE) ^ 26'(bus.sub_RNW),
            bus.sub_RNW, |bus.sub_BE, |bus.sub_DBus, |bus.sub_ABus,
            |bus.Sl_DBus, |bus.sub_select};
  endfunction

  task automatic idle_inputs();
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    bus.sub_xferAck = '0;
    bus.sub_retry   = '0;
    bus.sub_rdata   = {NS{32'h5A5A_5A5A}};
  endtask

  task automatic request(input logic [31:0] addr, input logic rnw,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = wdata;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int            cyc;
    int            tout;
    int            fwd;
    logic [NS-1:0] seen;
    logic [2:0]    resp;
    logic [31:0]   dbus;
    seen = '0; resp = R_NONE; dbus = '0; cyc = 0; tout = 0; fwd = 0;
    bus.sub_rdata = {NS{32'h5A5A_5A5A}};
    bus.sub_rdata[32*v.slave +: 32] = v.rdata;
    request(v.addr, v.rnw, v.wdata, v.be);
    while (cyc < 40 && resp == R_NONE) begin
      step();
      cyc++;
      bus.sub_xferAck = '0;
      bus.sub_retry   = '0;
      if (bus.Sl_toutSup) tout++;
      seen = seen | bus.sub_select;
      if ($countones(bus.sub_select) > 1)
        chk($sformatf("v%0d onehot", n), 32'(bus.sub_select), 32'(v.exp_sel));
      resp = {bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_retry};
      if (resp != R_NONE) begin
        dbus = bus.Sl_DBus;
      end else if (bus.sub_select != '0) begin
        if (fwd == 0) begin
          chk($sformatf("v%0d sub_ABus", n), bus.sub_ABus, v.addr);
          chk($sformatf("v%0d sub_DBus", n), bus.sub_DBus, v.wdata);
          chk($sformatf("v%0d sub_BE_RNW", n), {27'd0, bus.sub_BE, bus.sub_RNW}, {27'd0, v.be, v.rnw});
        end
        if (fwd == v.ack_dly) bus.sub_xferAck[v.slave] = 1'b1;
        if (fwd == v.rty_dly) bus.sub_retry[v.slave] = 1'b1;
        bus.sub_xferAck = bus.sub_xferAck | v.noise;
        bus.sub_retry   = bus.sub_retry | v.noise;
        fwd++;
      end
    end
    chk($sformatf("v%0d resp", n), 32'(resp), 32'(v.exp_resp));
    chk($sformatf("v%0d Sl_DBus", n), dbus, v.exp_dbus);
    chk($sformatf("v%0d sub_select", n), 32'(seen), 32'(v.exp_sel));
    chk($sformatf("v%0d latency", n), 32'(cyc), 32'(v.exp_cycle));
    chk($sformatf("v%0d toutSup_cycles", n), 32'(tout), 32'(v.exp_tout));
    idle_inputs();
    step();
    chk($sformatf("v%0d recover_quiet", n), 32'(resp_bits()), 32'd0);
    step();
    chk($sformatf("v%0d idle_quiet", n), 32'(resp_bits()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] acc;

    //          addr           rnw  wdata         be    slv ack rty noise   rdata         exp_sel  resp   exp_dbus      cyc tout
    vecs[0] = '{32'h0101_4204, 1'b1, 32'h0,        4'hF, 2,  2, -1, 4'b0000, 32'hDEADBEEF, 4'b0100, R_ACK, 32'hDEADBEEF, 4,  3};
    vecs[1] = '{32'h0101_4008, 1'b0, 32'h12345678, 4'hF, 0,  0, -1, 4'b0000, 32'hCAFEF00D, 4'b0001, R_ACK, 32'h0,        2,  1};
    vecs[2] = '{32'h0101_4300, 1'b1, 32'h0,        4'hF, 3, -1, -1, 4'b0111, 32'h11111111, 4'b1000, R_ERR, 32'h0,        13, 12};
    vecs[3] = '{32'h0101_4500, 1'b1, 32'h0,        4'hF, 0, -1, -1, 4'b0000, 32'h22222222, 4'b0000, R_ERR, 32'h0,        1,  0};
    vecs[4] = '{32'h0101_4104, 1'b1, 32'h0,        4'h3, 1, -1,  1, 4'b0000, 32'h33333333, 4'b0010, R_RTY, 32'h0,        3,  2};
    vecs[5] = '{32'h0101_43FC, 1'b1, 32'h0,        4'hF, 3, 11, -1, 4'b0000, 32'h0BADF00D, 4'b1000, R_ACK, 32'h0BADF00D, 13, 12};
    vecs[6] = '{32'h0101_4F00, 1'b0, 32'hA5A5A5A5, 4'hF, 0, -1, -1, 4'b0000, 32'h44444444, 4'b0000, R_ERR, 32'h0,        1,  0};
    vecs[7] = '{32'h0101_4108, 1'b1, 32'h0,        4'hC, 1,  1,  1, 4'b1101, 32'h13579BDF, 4'b0010, R_ACK, 32'h13579BDF, 3,  2};

    idle_inputs();
    OPB_Rst = 1'b1;
    #12;
    chk("reset_outputs", all_bits(), 32'd0);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    step();
    chk("post_reset_idle", all_bits(), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Master abort in the third FWD cycle.
    request(32'h0101_4204, 1'b1, 32'h0, 4'hF);
    step();
    chk("abort F0 sub_select", 32'(bus.sub_select), 32'h4);
    step();
    step();
    chk("abort F2 sub_select", 32'(bus.sub_select), 32'h4);
    bus.OPB_select = 1'b0;
    step();
    chk("abort sub_select_cleared", 32'(resp_bits()), 32'd0);
    acc = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      acc = acc | resp_bits();
    end
    chk("abort no_response", 32'(acc), 32'd0);

    // Select held through ACK: RECOVER must not start a new transfer.
    request(32'h0101_4000, 1'b1, 32'h0, 4'hF);
    bus.sub_rdata[31:0] = 32'h600D_CAFE;
    step();
    chk("b2b F0 sub_select", 32'(bus.sub_select), 32'h1);
    bus.sub_xferAck[0] = 1'b1;
    step();
    bus.sub_xferAck = '0;
    chk("b2b ack_data", bus.Sl_DBus, 32'h600D_CAFE);
    step();
    chk("b2b recover_quiet", 32'(resp_bits()), 32'd0);
    step();
    chk("b2b idle_quiet", 32'(resp_bits()), 32'd0);
    step();
    chk("b2b reselect", 32'(bus.sub_select), 32'h1);
    bus.OPB_select = 1'b0;
    step();
    step();

    // Reset mid-FWD clears everything before the next edge.
    request(32'h0101_4204, 1'b0, 32'h89ABCDEF, 4'hF);
    step();
    step();
    chk("rst_mid pre sub_select", 32'(bus.sub_select), 32'h4);
    #2;
    OPB_Rst = 1'b1;
    #1;
    chk("rst_mid outputs", all_bits(), 32'd0);
    idle_inputs();
    #2;
    OPB_Rst = 1'b0;
    step();
    chk("rst_mid after", all_bits(), 32'd0);

    // Address outside the window.
    request(32'h0200_0000, 1'b1, 32'h0, 4'hF);
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc = acc | resp_bits();
    end
    chk("miss no_outputs", 32'(acc), 32'd0);
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
